// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C wiper target and the controller that addresses it.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrite,
    StWriteAck,
    StRead,
    StReadAck,
    StWaitStop
  } i2c_state_e;

  localparam logic       I2C_ACK          = 1'b0;
  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h2F;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a glitch filter; the output follows the input only
// after FILTER_LEN identical consecutive synchronized samples.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_line,
  output logic o_line
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_out;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      r_out  <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_line};
      if (r_sync[1] == r_out) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_out <= r_sync[1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_line = r_out;

endmodule

// File: rtl/i2c_wiper_target.sv
// I2C target emulating a single-register digital potentiometer: written bytes are clamped
// into the wiper register, reads return it. SDA is only ever pulled low, SCL never stretched.
module i2c_wiper_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  ADDR        = I2C_DEFAULT_ADDR,
  parameter logic [7:0]  RESET_VALUE = 8'd64,
  parameter logic [7:0]  MAX_VALUE   = 8'd127,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] wiper,
  output logic       wr_strobe,
  output logic       busy
);

  logic w_scl, w_sda;
  logic r_scl_prev, r_sda_prev;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk    (clk),
    .reset_n(reset_n),
    .i_line (scl_in),
    .o_line (w_scl)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk    (clk),
    .reset_n(reset_n),
    .i_line (sda_in),
    .o_line (w_sda)
  );

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

  i2c_state_e r_state, w_state_d;
  logic [2:0] r_bitcnt, w_bitcnt_d;
  logic [7:0] r_shift, w_shift_d, r_tx, w_tx_d, r_wiper, w_wiper_d;
  logic       r_rw, w_rw_d, r_wr_strobe, w_wr_strobe_d;
  logic       r_sda_oe, w_sda_oe_d, r_busy, w_busy_d;
  logic [7:0] w_byte, w_clamped;

  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_clamped = (w_byte > MAX_VALUE) ? MAX_VALUE : w_byte;

  always_comb begin
    w_state_d     = r_state;
    w_bitcnt_d    = r_bitcnt;
    w_shift_d     = r_shift;
    w_tx_d        = r_tx;
    w_wiper_d     = r_wiper;
    w_rw_d        = r_rw;
    w_wr_strobe_d = 1'b0;
    w_sda_oe_d    = r_sda_oe;
    w_busy_d      = r_busy;
    if (w_start) begin
      w_state_d  = StAddr;
      w_bitcnt_d = '0;
      w_sda_oe_d = 1'b0;
    end else if (w_stop) begin
      w_state_d  = StIdle;
      w_sda_oe_d = 1'b0;
      w_busy_d   = 1'b0;
    end else begin
      case (r_state)
        StIdle: ;
        StAddr: begin
          if (w_scl_rise) begin
            w_shift_d  = w_byte;
            w_bitcnt_d = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              w_rw_d = w_sda;
              if (r_shift[6:0] == ADDR) begin
                w_state_d = StAddrAck;
                w_busy_d  = 1'b1;
              end else begin
                w_state_d = StWaitStop;
                w_busy_d  = 1'b0;
              end
            end
          end
        end
        // First fall drives ACK, second fall releases it (and starts a read).
        StAddrAck: begin
          if (w_scl_fall) begin
            w_bitcnt_d = '0;
            if (!r_sda_oe) begin
              w_sda_oe_d = ~I2C_ACK;
            end else if (r_rw) begin
              w_state_d  = StRead;
              w_sda_oe_d = ~r_wiper[7];
              w_tx_d     = {r_wiper[6:0], 1'b0};
            end else begin
              w_state_d  = StWrite;
              w_sda_oe_d = 1'b0;
            end
          end
        end
        StWrite: begin
          if (w_scl_rise) begin
            w_shift_d  = w_byte;
            w_bitcnt_d = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              w_wiper_d     = w_clamped;
              w_wr_strobe_d = 1'b1;
              w_state_d     = StWriteAck;
            end
          end
        end
        StWriteAck: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_d = ~I2C_ACK;
            end else begin
              w_sda_oe_d = 1'b0;
              w_state_d  = StWrite;
              w_bitcnt_d = '0;
            end
          end
        end
        // Counter holds SCL rises seen; zero at a fall means all 8 bits were clocked out.
        StRead: begin
          if (w_scl_rise) begin
            w_bitcnt_d = r_bitcnt + 3'd1;
          end else if (w_scl_fall) begin
            if (r_bitcnt == 3'd0) begin
              w_sda_oe_d = 1'b0;
              w_state_d  = StReadAck;
            end else begin
              w_sda_oe_d = ~r_tx[7];
              w_tx_d     = {r_tx[6:0], 1'b0};
            end
          end
        end
        StReadAck: begin
          if (w_scl_rise) begin
            if (w_sda == I2C_ACK) begin
              w_tx_d     = r_wiper;
              w_bitcnt_d = 3'd1;
            end else begin
              w_state_d = StWaitStop;
            end
          end else if (w_scl_fall && r_bitcnt == 3'd1) begin
            w_sda_oe_d = ~r_tx[7];
            w_tx_d     = {r_tx[6:0], 1'b0};
            w_bitcnt_d = '0;
            w_state_d  = StRead;
          end
        end
        StWaitStop: w_sda_oe_d = 1'b0;
        default: begin
          w_state_d  = StIdle;
          w_sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_scl_prev  <= 1'b1;
      r_sda_prev  <= 1'b1;
      r_state     <= StIdle;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_tx        <= '0;
      r_wiper     <= RESET_VALUE;
      r_rw        <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_scl_prev  <= w_scl;
      r_sda_prev  <= w_sda;
      r_state     <= w_state_d;
      r_bitcnt    <= w_bitcnt_d;
      r_shift     <= w_shift_d;
      r_tx        <= w_tx_d;
      r_wiper     <= w_wiper_d;
      r_rw        <= w_rw_d;
      r_wr_strobe <= w_wr_strobe_d;
      r_sda_oe    <= w_sda_oe_d;
      r_busy      <= w_busy_d;
    end
  end

  assign sda_oe    = r_sda_oe;
  assign wiper     = r_wiper;
  assign wr_strobe = r_wr_strobe;
  assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_wiper_target.sv
// Directed bench for i2c_wiper_target: a 100 kHz bus master model on a 16 MHz clock.
module tb_i2c_wiper_target;
  import i2c_pkg::*;

  localparam int Q = 40;  // quarter SCL period in clocks

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_strobe, busy;
  logic [7:0] wiper;

  int n_cmp = 0;
  int n_bad = 0;
  int n_strobe = 0;
  int n_hi_chg = 0;
  bit oe_seen = 1'b0;
  logic prev_oe = 1'b0;

  always #31 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;

  i2c_wiper_target dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl_in   (scl_m),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .wiper    (wiper),
    .wr_strobe(wr_strobe),
    .busy     (busy)
  );

  always @(posedge clk) begin
    if (wr_strobe === 1'b1) n_strobe++;
    if (sda_oe === 1'b1) oe_seen = 1'b1;
    if (reset_n && sda_oe !== prev_oe && scl_m === 1'b1) n_hi_chg++;
    prev_oe = sda_oe;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(master_ack);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL rst_oe: got %b want 0", sda_oe); end
    n_cmp++; if (wiper !== 8'd64) begin n_bad++; $display("FAIL rst_wiper: got %0h want 40", wiper); end
    n_cmp++; if (wr_strobe !== 1'b0) begin n_bad++; $display("FAIL rst_strobe: got %b want 0", wr_strobe); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_mismatch();
    logic ack;
    int s0;
    s0 = n_strobe;
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h5C, ack);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL mis_addr_ack: got %b want 1", ack); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mis_busy: got %b want 0", busy); end
    write_byte(8'h10, ack);
    i2c_stop();
    tick(20);
    n_cmp++; if (oe_seen !== 1'b0) begin n_bad++; $display("FAIL mis_oe: got %b want 0", oe_seen); end
    n_cmp++; if (wiper !== 8'd64) begin n_bad++; $display("FAIL mis_wiper: got %0h want 40", wiper); end
    n_cmp++; if (n_strobe - s0 !== 0) begin n_bad++; $display("FAIL mis_strobe: got %0d want 0", n_strobe - s0); end
  endtask

  task automatic test_write();
    logic ack;
    int s0;
    s0 = n_strobe;
    i2c_start();
    write_byte(8'h5E, ack);
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL wr_addr_ack: got %b want 0", ack); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %b want 1", busy); end
    write_byte(8'h4B, ack);
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL wr_data_ack: got %b want 0", ack); end
    i2c_stop();
    tick(20);
    n_cmp++; if (wiper !== 8'h4B) begin n_bad++; $display("FAIL wr_wiper: got %0h want 4b", wiper); end
    n_cmp++; if (n_strobe - s0 !== 1) begin n_bad++; $display("FAIL wr_strobe: got %0d want 1", n_strobe - s0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'h5F, ack);
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
    read_byte(d, 1'b0);
    n_cmp++; if (d !== 8'h4B) begin n_bad++; $display("FAIL rd_byte1: got %0h want 4b", d); end
    read_byte(d, 1'b1);
    n_cmp++; if (d !== 8'h4B) begin n_bad++; $display("FAIL rd_byte2: got %0h want 4b", d); end
    tick(Q);
    n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL rd_nack_oe: got %b want 0", sda_oe); end
    n_cmp++;
    if (dut.r_state !== StWaitStop) begin
      n_bad++; $display("FAIL rd_wait_stop: got %0d want %0d", dut.r_state, StWaitStop);
    end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy: got %b want 1", busy); end
    i2c_stop();
    tick(20);
    n_cmp++;
    if (dut.r_state !== StIdle) begin
      n_bad++; $display("FAIL rd_idle: got %0d want %0d", dut.r_state, StIdle);
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_clamp();
    logic ack;
    int s0;
    i2c_start();
    write_byte(8'h5E, ack);
    write_byte(8'hC8, ack);
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL cl_ack: got %b want 0", ack); end
    n_cmp++; if (wiper !== 8'h7F) begin n_bad++; $display("FAIL cl_wiper: got %0h want 7f", wiper); end
    s0 = n_strobe;
    write_byte(8'h05, ack);
    n_cmp++; if (wiper !== 8'h05) begin n_bad++; $display("FAIL cl_mid: got %0h want 05", wiper); end
    write_byte(8'h22, ack);
    i2c_stop();
    tick(20);
    n_cmp++; if (n_strobe - s0 !== 2) begin n_bad++; $display("FAIL cl_strobes: got %0d want 2", n_strobe - s0); end
    n_cmp++; if (wiper !== 8'h22) begin n_bad++; $display("FAIL cl_final: got %0h want 22", wiper); end
  endtask

  task automatic test_interrupt();
    logic ack;
    logic [7:0] d;
    int s0;
    s0 = n_strobe;
    i2c_start();
    write_byte(8'h5E, ack);
    write_bit(1'b0); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_start();
    write_byte(8'h5F, ack);
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL int_addr_ack: got %b want 0", ack); end
    read_byte(d, 1'b1);
    i2c_stop();
    tick(20);
    n_cmp++; if (d !== 8'h22) begin n_bad++; $display("FAIL int_read: got %0h want 22", d); end
    n_cmp++; if (wiper !== 8'h22) begin n_bad++; $display("FAIL int_wiper: got %0h want 22", wiper); end
    n_cmp++; if (n_strobe - s0 !== 0) begin n_bad++; $display("FAIL int_strobe: got %0d want 0", n_strobe - s0); end
  endtask

  task automatic test_glitch_reset();
    logic ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'h5E, ack);
    d = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) begin
        sda_m = d[i]; tick(Q);
        scl_m = 1'b1; tick(Q);
        scl_m = 1'b0; tick(2);
        scl_m = 1'b1; tick(Q);
        scl_m = 1'b0; tick(Q);
      end else begin
        write_bit(d[i]);
      end
    end
    read_bit(ack);
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL gl_ack: got %b want 0", ack); end
    n_cmp++; if (wiper !== 8'h3C) begin n_bad++; $display("FAIL gl_wiper: got %0h want 3c", wiper); end
    d = 8'h11;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    n_cmp++; if (sda_oe !== 1'b1) begin n_bad++; $display("FAIL rs_pre_oe: got %b want 1", sda_oe); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL rs_oe: got %b want 0", sda_oe); end
    n_cmp++; if (wiper !== 8'd64) begin n_bad++; $display("FAIL rs_wiper: got %0h want 40", wiper); end
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(20);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rs_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_mismatch();
    test_write();
    test_read();
    test_clamp();
    test_interrupt();
    test_glitch_reset();
    n_cmp++;
    if (n_hi_chg !== 0) begin
      n_bad++; $display("FAIL sda_scl_high: got %0d changes want 0", n_hi_chg);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
